gpio_bank_ctrl: RTL

//  Parametrised GPIO bank for a team project top: per-pin output/direction regs, input

---
 rtl/gpio_bank_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/gpio_bank_ctrl.sv
// Parametrised GPIO bank: output/direction registers, input synchroniser, edge-detect
// interrupt with sticky W1C pending bits. Optional input debounce via `GPIO_DEBOUNCE_EN.
module gpio_bank_ctrl #(
    parameter int NPINS       = 34,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic [2:0]       reg_addr,
    input  logic             reg_we,
    input  logic [NPINS-1:0] reg_wdata,
    output logic [NPINS-1:0] reg_rdata,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oeb,
    output logic             irq
);

    localparam logic [2:0] ADDR_OUT  = 3'd0;
    localparam logic [2:0] ADDR_OE   = 3'd1;
    localparam logic [2:0] ADDR_IN   = 3'd2;
    localparam logic [2:0] ADDR_RISE = 3'd3;
    localparam logic [2:0] ADDR_FALL = 3'd4;
    localparam logic [2:0] ADDR_PEND = 3'd5;

    logic [NPINS-1:0] out_q, oe_q, rise_en_q, fall_en_q;
    logic [NPINS-1:0] pend_q, pend_d;
    logic [NPINS-1:0] prev_q;
    logic [NPINS-1:0] sync_q [SYNC_STAGES];
    logic [NPINS-1:0] in_s, rise_s, fall_s, set_s, clr_s;
    logic             irq_q, irq_d;

    // Control register writes; ignored while the bank is disabled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (en && reg_we) begin
            case (reg_addr)
                ADDR_OUT:  out_q     <= reg_wdata;
                ADDR_OE:   oe_q      <= reg_wdata;
                ADDR_RISE: rise_en_q <= reg_wdata;
                ADDR_FALL: fall_en_q <= reg_wdata;
                default: ;
            endcase
        end
    end

    // Pad input synchroniser chain; keeps running while disabled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES);

    logic [NPINS-1:0] filt_q;
    logic [CNT_W-1:0] cnt_q [NPINS];

    // Filtered value follows the synced value only after DB_CYCLES consecutive disagreements.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            filt_q <= '0;
            for (int i = 0; i < NPINS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NPINS; i++) begin
                if (sync_q[SYNC_STAGES-1][i] != filt_q[i]) begin
                    if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
                        filt_q[i] <= sync_q[SYNC_STAGES-1][i];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i]  <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign in_s = filt_q;
`else
    logic [31:0] db_cycles_unused_s;
    assign db_cycles_unused_s = DB_CYCLES;
    assign in_s = sync_q[SYNC_STAGES-1];
`endif

    // Edge detection and pending next state; a new edge outranks a same-cycle W1C.
    always_comb begin
        rise_s = in_s & ~prev_q;
        fall_s = ~in_s & prev_q;
        if (en) begin
            set_s = (rise_s & rise_en_q) | (fall_s & fall_en_q);
        end else begin
            set_s = '0;
        end
        if (en && reg_we && (reg_addr == ADDR_PEND)) begin
            clr_s = reg_wdata;
        end else begin
            clr_s = '0;
        end
        pend_d = (pend_q & ~clr_s) | set_s;
        irq_d  = en & (|pend_q);
    end

    // Edge history, sticky pending bits and the registered interrupt.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_q <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= in_s;
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    // Register read mux.
    always_comb begin
        case (reg_addr)
            ADDR_OUT:  reg_rdata = out_q;
            ADDR_OE:   reg_rdata = oe_q;
            ADDR_IN:   reg_rdata = in_s;
            ADDR_RISE: reg_rdata = rise_en_q;
            ADDR_FALL: reg_rdata = fall_en_q;
            ADDR_PEND: reg_rdata = pend_q;
            default:   reg_rdata = '0;
        endcase
    end

    assign gpio_out = en ? out_q : '0;
    assign gpio_oeb = en ? ~oe_q : '1;
    assign irq      = irq_q;

endmodule
